// File: rtl/reflet_mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reflet_mem_sequencer_pkg
// Brief   : Shared state encoding and byte-lane mask helper for the sequencer.
// Revision: 1.0  initial release
// ============================================================================
package reflet_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    // Bit bit_idx of the (1 << (8 << size)) - 1 mask; evaluated per bit so a
    // full-word size never needs a shift wider than the word.
    function automatic logic size_mask_bit(input int size, input int bit_idx);
        if (size > 6) begin
            return 1'b1;
        end
        return bit_idx < (8 << size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reflet_byte_lane_merge.sv
`default_nettype none
// ============================================================================
// Module  : reflet_byte_lane_merge
// Brief   : Combinational byte-lane extract (reads) and merge (sub-word RMW).
// Revision: 1.0  initial release
// ============================================================================
module reflet_byte_lane_merge
    import reflet_mem_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int OFF_W     = $clog2(WORD_SIZE / 8),
    parameter int SIZE_W    = OFF_W + 1
) (
    input  logic [WORD_SIZE-1:0] old_word,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [OFF_W-1:0]     offset,
    input  logic [SIZE_W-1:0]    size,
    output logic [WORD_SIZE-1:0] merged_word,
    output logic [WORD_SIZE-1:0] extracted_read
);

    logic [WORD_SIZE-1:0] mask;
    logic [OFF_W+2:0]     shift;

    assign shift = {offset, 3'b000};

    always_comb begin
        mask = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            mask[i] = size_mask_bit(int'(size), i);
        end
    end

    assign extracted_read = (old_word >> shift) & mask;
    assign merged_word    = (old_word & ~(mask << shift)) | ((wdata & mask) << shift);

endmodule
`default_nettype wire

// File: rtl/reflet_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reflet_mem_sequencer
// Brief   : Round-robin sequencer sharing one single-port RAM between fetch and
//           data ports; sub-word writes run as read-modify-write.
// Revision: 1.0  initial release
// ============================================================================
module reflet_mem_sequencer
    import reflet_mem_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              inst_req,
    input  logic [ADDR_SIZE-1:0]              inst_addr,
    output logic [WORD_SIZE-1:0]              inst_data,
    output logic                              inst_ack,
    input  logic                              data_req,
    input  logic [ADDR_SIZE-1:0]              data_addr,
    input  logic                              data_write_en,
    input  logic [$clog2(WORD_SIZE/8):0]      data_size,
    input  logic [WORD_SIZE-1:0]              data_wdata,
    output logic [WORD_SIZE-1:0]              data_rdata,
    output logic                              data_ack,
    output logic                              data_align_error,
    output logic [ADDR_SIZE-1:0]              ram_addr,
    output logic [WORD_SIZE-1:0]              ram_data_out,
    input  logic [WORD_SIZE-1:0]              ram_data_in,
    output logic                              ram_write_en
);

    localparam int OFF_W  = $clog2(WORD_SIZE / 8);
    localparam int SIZE_W = OFF_W + 1;
    localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(OFF_W);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_data_q, gnt_data_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [OFF_W-1:0]      offset_q, offset_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]  inst_data_q, inst_data_d;
    logic [WORD_SIZE-1:0]  data_rdata_q, data_rdata_d;
    logic [ADDR_SIZE-1:0]  ram_addr_q, ram_addr_d;
    logic [WORD_SIZE-1:0]  ram_data_out_q, ram_data_out_d;

    logic                  grant_data;
    logic [ADDR_SIZE-1:0]  req_addr;
    logic                  misaligned;
    logic                  oversize;
    logic [WORD_SIZE-1:0]  merged_word;
    logic [WORD_SIZE-1:0]  extracted_read;

    reflet_byte_lane_merge #(
        .WORD_SIZE (WORD_SIZE),
        .OFF_W     (OFF_W),
        .SIZE_W    (SIZE_W)
    ) u_merge (
        .old_word       (ram_data_in),
        .wdata          (wdata_q),
        .offset         (offset_q),
        .size           (size_q),
        .merged_word    (merged_word),
        .extracted_read (extracted_read)
    );

    // Inst wins unless data is alone or inst had the previous grant.
    assign grant_data = data_req && (!inst_req || (last_grant_q == GRANT_INST));
    assign req_addr   = grant_data ? data_addr : inst_addr;
    assign oversize   = data_size > FULL_SIZE;

    always_comb begin
        misaligned = 1'b0;
        for (int i = 0; i < OFF_W; i++) begin
            misaligned = misaligned || (data_addr[i] && (int'(data_size) > i));
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        gnt_data_d     = gnt_data_q;
        err_d          = err_q;
        we_d           = we_q;
        offset_d       = offset_q;
        size_d         = size_q;
        wdata_d        = wdata_q;
        inst_data_d    = inst_data_q;
        data_rdata_d   = data_rdata_q;
        ram_addr_d     = ram_addr_q;
        ram_data_out_d = ram_data_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    gnt_data_d   = grant_data;
                    last_grant_d = grant_data;
                    err_d        = 1'b0;
                    offset_d     = req_addr[OFF_W-1:0];
                    ram_addr_d   = {req_addr[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                    if (grant_data) begin
                        size_d  = data_size;
                        wdata_d = data_wdata;
                        we_d    = data_write_en;
                    end else begin
                        size_d  = FULL_SIZE;
                        we_d    = 1'b0;
                    end

                    if (grant_data && (misaligned || oversize)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (grant_data && data_write_en && (data_size == FULL_SIZE)) begin
                        ram_data_out_d = data_wdata;
                        state_d        = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (we_q) begin
                    ram_data_out_d = merged_word;
                    state_d        = ST_WRITE;
                end else begin
                    if (gnt_data_q) begin
                        data_rdata_d = extracted_read;
                    end else begin
                        inst_data_d = ram_data_in;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= GRANT_DATA;
            gnt_data_q     <= 1'b0;
            err_q          <= 1'b0;
            we_q           <= 1'b0;
            offset_q       <= '0;
            size_q         <= '0;
            wdata_q        <= '0;
            inst_data_q    <= '0;
            data_rdata_q   <= '0;
            ram_addr_q     <= '0;
            ram_data_out_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            gnt_data_q     <= gnt_data_d;
            err_q          <= err_d;
            we_q           <= we_d;
            offset_q       <= offset_d;
            size_q         <= size_d;
            wdata_q        <= wdata_d;
            inst_data_q    <= inst_data_d;
            data_rdata_q   <= data_rdata_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_out_q <= ram_data_out_d;
        end
    end

    assign inst_data        = inst_data_q;
    assign data_rdata       = data_rdata_q;
    assign ram_addr         = ram_addr_q;
    assign ram_data_out     = ram_data_out_q;
    assign inst_ack         = (state_q == ST_DONE) && !gnt_data_q;
    assign data_ack         = (state_q == ST_DONE) && gnt_data_q;
    assign data_align_error = (state_q == ST_DONE) && gnt_data_q && err_q;
    assign ram_write_en     = (state_q == ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_reflet_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reflet_mem_sequencer
// Brief   : Directed self-checking bench with a synchronous RAM model.
// Revision: 1.0  initial release
// ============================================================================
module tb_reflet_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_ack;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_write_en;
    logic [2:0]  data_size;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        data_align_error;
    logic [31:0] ram_addr;
    logic [31:0] ram_data_out;
    logic [31:0] ram_data_in;
    logic        ram_write_en;

    logic [31:0] mem [0:4095];

    int vectors    = 0;
    int miscompares = 0;

    reflet_mem_sequencer #(.WORD_SIZE(32), .ADDR_SIZE(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_data        (inst_data),
        .inst_ack         (inst_ack),
        .data_req         (data_req),
        .data_addr        (data_addr),
        .data_write_en    (data_write_en),
        .data_size        (data_size),
        .data_wdata       (data_wdata),
        .data_rdata       (data_rdata),
        .data_ack         (data_ack),
        .data_align_error (data_align_error),
        .ram_addr         (ram_addr),
        .ram_data_out     (ram_data_out),
        .ram_data_in      (ram_data_in),
        .ram_write_en     (ram_write_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) begin
            mem[ram_addr[13:2]] <= ram_data_out;
        end
        ram_data_in <= mem[ram_addr[13:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One data transaction; returns ack latency (-1 on timeout) and the first
    // write strobe cycle (0 if none) with its write word.
    task automatic run_data(input logic [31:0] addr, input logic we, input logic [2:0] size,
                            input logic [31:0] wd, output int lat, output int we_cyc,
                            output logic [31:0] wr_word, output logic err,
                            output logic [31:0] rd);
        lat = -1; we_cyc = 0; wr_word = '0; err = 1'b0; rd = '0;
        data_addr = addr; data_write_en = we; data_size = size; data_wdata = wd;
        data_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ram_write_en && we_cyc == 0) begin
                we_cyc  = i;
                wr_word = ram_data_out;
            end
            if (data_ack) begin
                lat = i;
                err = data_align_error;
                rd  = data_rdata;
                break;
            end
        end
        data_req = 1'b0;
        step();
    endtask

    int          lat, we_cyc, n_acks;
    logic [31:0] wr_word, rd;
    logic        err, want_data, saw_bad;
    logic [31:0] inst_list [0:2];
    logic [31:0] data_list [0:2];
    int          ii, di;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h400] = 32'h11223344;   // 0x1000
        mem[12'h800] = 32'hCAFEF00D;   // 0x2000
        reset = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h2000;
        data_req = 1'b1; data_addr = 32'h1000; data_write_en = 1'b0;
        data_size = 3'd2; data_wdata = '0;
        step(); step();
        check("rst_inst_ack",  {63'd0, inst_ack}, 64'd0);
        check("rst_data_ack",  {63'd0, data_ack}, 64'd0);
        check("rst_align_err", {63'd0, data_align_error}, 64'd0);
        check("rst_ram_we",    {63'd0, ram_write_en}, 64'd0);
        check("rst_outputs",   {32'd0, inst_data | data_rdata | ram_addr | ram_data_out}, 64'd0);

        // Contention right after reset: inst first, data after.
        reset = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (data_ack) begin lat = 100 + i; break; end
            if (inst_ack) begin lat = i; break; end
        end
        check("post_rst_inst_first_lat", 64'(lat), 64'd3);
        check("post_rst_inst_data", {32'd0, inst_data}, 64'hCAFEF00D);
        inst_req = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (data_ack) begin lat = i; break; end
        end
        check("post_rst_data_lat", 64'(lat), 64'd4);
        check("post_rst_data_rdata", {32'd0, data_rdata}, 64'h11223344);
        data_req = 1'b0;
        step();

        run_data(32'h1001, 1'b1, 3'd0, 32'hFFFFFFAB, lat, we_cyc, wr_word, err, rd);
        check("bytewr_we_cycle", 64'(we_cyc), 64'd3);
        check("bytewr_word", {32'd0, wr_word}, 64'h1122AB44);
        check("bytewr_lat", 64'(lat), 64'd4);
        check("bytewr_err", {63'd0, err}, 64'd0);

        run_data(32'h1002, 1'b0, 3'd1, 32'h0, lat, we_cyc, wr_word, err, rd);
        check("halfrd_rdata", {32'd0, rd}, 64'h00001122);
        check("halfrd_lat", 64'(lat), 64'd3);

        run_data(32'h1001, 1'b1, 3'd1, 32'h5555, lat, we_cyc, wr_word, err, rd);
        check("misalign_lat", 64'(lat), 64'd1);
        check("misalign_err", {63'd0, err}, 64'd1);
        check("misalign_no_we", 64'(we_cyc), 64'd0);

        run_data(32'h1000, 1'b0, 3'd3, 32'h0, lat, we_cyc, wr_word, err, rd);
        check("oversize_lat", 64'(lat), 64'd1);
        check("oversize_err", {63'd0, err}, 64'd1);

        run_data(32'h1004, 1'b1, 3'd2, 32'hDEADBEEF, lat, we_cyc, wr_word, err, rd);
        check("fullwr_we_cycle", 64'(we_cyc), 64'd1);
        check("fullwr_word", {32'd0, wr_word}, 64'hDEADBEEF);
        check("fullwr_lat", 64'(lat), 64'd2);
        check("fullwr_err", {63'd0, err}, 64'd0);

        run_data(32'h1007, 1'b0, 3'd0, 32'h0, lat, we_cyc, wr_word, err, rd);
        check("byterd_top_rdata", {32'd0, rd}, 64'h000000DE);

        run_data(32'h1006, 1'b1, 3'd1, 32'hAAAA1234, lat, we_cyc, wr_word, err, rd);
        check("halfwr_word", {32'd0, wr_word}, 64'h1234BEEF);
        check("halfwr_lat", 64'(lat), 64'd4);

        run_data(32'h1004, 1'b0, 3'd2, 32'h0, lat, we_cyc, wr_word, err, rd);
        check("wordrd_rdata", {32'd0, rd}, 64'h1234BEEF);
        check("wordrd_err", {63'd0, err}, 64'd0);

        // Six contended transactions; last grant was data, so inst leads.
        inst_list[0] = 32'h2000; inst_list[1] = 32'h1000; inst_list[2] = 32'h1004;
        data_list[0] = 32'h1004; data_list[1] = 32'h2000; data_list[2] = 32'h1000;
        ii = 0; di = 0;
        inst_addr = inst_list[0]; inst_req = 1'b1;
        data_addr = data_list[0]; data_write_en = 1'b0; data_size = 3'd2; data_req = 1'b1;
        want_data = 1'b0;
        n_acks = 0;
        for (int t = 0; t < 6; t++) begin
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                step();
                if (inst_ack || data_ack) begin lat = i; break; end
            end
            check("cont_ack_seen", 64'(lat > 0), 64'd1);
            check("cont_grant_order", {63'd0, data_ack}, {63'd0, want_data});
            if (inst_ack) begin
                check("cont_inst_data", {32'd0, inst_data},
                      {32'd0, (ii == 0) ? 32'hCAFEF00D : (ii == 1) ? 32'h1122AB44 : 32'h1234BEEF});
                ii++;
                if (ii < 3) inst_addr = inst_list[ii]; else inst_req = 1'b0;
                n_acks++;
            end else if (data_ack) begin
                check("cont_data_rdata", {32'd0, data_rdata},
                      {32'd0, (di == 0) ? 32'h1234BEEF : (di == 1) ? 32'hCAFEF00D : 32'h1122AB44});
                di++;
                if (di < 3) data_addr = data_list[di]; else data_req = 1'b0;
                n_acks++;
            end
            want_data = ~want_data;
        end
        check("cont_total_acks", 64'(n_acks), 64'd6);
        inst_req = 1'b0; data_req = 1'b0;
        step(); step();

        // Reset during CAPTURE of a byte write must abort it silently.
        data_addr = 32'h1000; data_write_en = 1'b1; data_size = 3'd0; data_wdata = 32'h55;
        data_req = 1'b1;
        saw_bad = 1'b0;
        step();   // READ
        saw_bad = saw_bad | ram_write_en | data_ack;
        step();   // CAPTURE
        saw_bad = saw_bad | ram_write_en | data_ack;
        reset = 1'b1; data_req = 1'b0;
        step();
        saw_bad = saw_bad | ram_write_en | data_ack;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            saw_bad = saw_bad | ram_write_en | data_ack | inst_ack;
        end
        check("abort_no_we_no_ack", {63'd0, saw_bad}, 64'd0);
        check("abort_mem_intact", {32'd0, mem[12'h400]}, 64'h1122AB44);

        run_data(32'h1000, 1'b0, 3'd2, 32'h0, lat, we_cyc, wr_word, err, rd);
        check("after_abort_rdata", {32'd0, rd}, 64'h1122AB44);
        check("after_abort_lat", 64'(lat), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reflet_mem_sequencer.md
Name: reflet_mem_sequencer

Overview:
Sequences and arbitrates one word-aligned, single-port synchronous RAM between two requesters: an instruction-fetch port and a CPU data port.
- Instruction port: full-word reads only.
- Data port: byte, half and word reads and writes of any size up to word_size.
- Sub-word writes are executed as an explicit read-modify-write (RMW) over several cycles. There is no combinational same-cycle merge.
- Sits between the CPU core and the RAM/bus, replacing direct CPU-to-RAM wiring.

Parameters:
word_size, 32, data width in bits; must be a multiple of 8, power of two.
addr_size, 32, byte address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request; held with inst_addr until inst_ack
inst_addr  in  addr_size  fetch byte address; low $clog2(word_size/8) bits ignored
inst_data  out  word_size  fetched word; valid with inst_ack, held until next inst_ack
inst_ack  out  1  one-cycle completion pulse
data_req  in  1  data request; held with all data_* inputs until data_ack
data_addr  in  addr_size  data byte address
data_write_en  in  1  1 = write, 0 = read
data_size  in  $clog2(word_size/8)+1  access is 2^data_size bytes
data_wdata  in  word_size  write data, right-aligned
data_rdata  out  word_size  read data, right-aligned, zero-extended; held until next data_ack
data_ack  out  1  one-cycle completion pulse
data_align_error  out  1  qualifies data_ack: request rejected
ram_addr  out  addr_size  word-aligned address
ram_data_out  out  word_size  write word
ram_data_in  in  word_size  read word, valid the cycle after ram_addr is presented
ram_write_en  out  1  write strobe

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (reset).
- States: IDLE, READ, CAPTURE, WRITE, DONE. Encoding is a shared localparam.
- On reset:
  - state=IDLE
  - all acks, data_align_error, ram_write_en = 0
  - inst_data, data_rdata, ram_addr, ram_data_out = 0
  - last_grant = data, so inst wins the first contention.
- IDLE, arbitration:
  - If only one requester has req high, grant it.
  - If both are high, grant the port not in last_grant (round-robin).
  - Latch addr, size, wdata and write_en into internal registers, and record the grant in last_grant.
- Transition out of IDLE on grant:
  - Data request with addr & ((1<<size)-1) != 0, or size > $clog2(word_size/8) → DONE with error. No RAM access.
  - Data write with size == $clog2(word_size/8) (aligned full word) → WRITE directly.
  - Anything else, including all inst fetches → READ.
- READ: ram_addr = latched addr with low bits cleared, ram_write_en=0. Next state CAPTURE.
- CAPTURE: sample ram_data_in.
  - Read: data_rdata = (word >> off*8) & mask, or inst_data = word. Next state DONE.
  - Sub-word write: register the merged word. Next state WRITE.
  - off = addr low bits; mask = (1 << (8<<size)) - 1, computed without overflow when 8<<size == word_size.
  - merged = (old & ~(mask<<off*8)) | ((wdata & mask) << off*8).
- WRITE: ram_write_en=1 for exactly this cycle. ram_data_out = merged word or full wdata. Next state DONE.
- DONE:
  - Pulse the granted port's ack. data_align_error=1 only for the error path; it is low on every other data_ack and with inst_ack.
  - Next state IDLE, unconditionally.
- Latency from the cycle req is sampled in IDLE to the cycle ack is high:
  - read: 3
  - aligned full-word write: 2
  - sub-word write: 4
  - error: 1
- No pipelining; one transaction at a time. The ungranted requester waits with req held.
- Request inputs change after grant: ignored, because the latched copies are used.
- Requester drops req in the cycle after ack. If req is still high in the IDLE after DONE, it is treated as a new request.
- Reset mid-operation:
  - Aborts the transaction; no ack is produced.
  - Reset in READ or CAPTURE guarantees no RAM write.
  - ram_write_en is decoded from state, so reset during WRITE does not suppress the write in that same cycle.

Decomposition:
- Shared header (reflet_mem_sequencer_defs): state localparams and the size→mask helper function.
- One natural sub-module: reflet_byte_lane_merge. It is combinational: (old_word, wdata, offset, size) → (merged_word, extracted_read).
- The FSM, arbiter and registers stay in the top.

Test Plan:
- Reset: assert reset 2 cycles with both reqs high → all outputs 0. After release, inst is granted first; the data port's grant follows inst's ack.
- Byte write: RAM[0x1000]=0x11223344; data write, addr 0x1001, size 0, wdata 0xFFFFFFAB → ram_write_en pulses 3 cycles after the request is sampled, with ram_data_out 0x1122AB44; data_ack 1 cycle later, error=0.
- Half read: same word, addr 0x1002, size 1 → data_rdata 0x00001122, data_ack 3 cycles after the request is sampled.
- Misaligned: addr 0x1001, size 1, write → data_ack+data_align_error 1 cycle after the request is sampled; ram_write_en never high.
- Contention: inst_req and data_req held high for 6 transactions → grants alternate inst, data, inst, ...; neither port is starved; each ack matches its own address.
- Reset in CAPTURE of a byte write → no ram_write_en, no data_ack; the next request completes normally.
